// File: rtl/clock_pkg.sv
// -----------------------------------------------------------------------------
// clock_pkg
// Shared definitions for the clock codebase.
//   set_state_e     : set-FSM encoding (RUN, SET_HR, SET_MIN)
//   SEC_MAX_DEFAULT : default terminal seconds value
//   MIN_MAX_DEFAULT : default terminal minutes value
//   wrap_inc()      : 6-bit increment that wraps from a terminal value to zero
// -----------------------------------------------------------------------------
package clock_pkg;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        SET_HR  = 2'd1,
        SET_MIN = 2'd2
    } set_state_e;

    localparam int SEC_MAX_DEFAULT = 59;
    localparam int MIN_MAX_DEFAULT = 59;

    // Compare-and-wrap rather than a modulo, so the result never exceeds top.
    function automatic logic [5:0] wrap_inc(input logic [5:0] value,
                                            input logic [5:0] top);
        if (value >= top) begin
            return 6'd0;
        end
        return value + 6'd1;
    endfunction

endpackage

// File: rtl/edge_detect.sv
// -----------------------------------------------------------------------------
// edge_detect
// Registers a level input and flags its rising edge.
//   clk  : sampling clock
//   rst  : asynchronous, active-high reset
//   sig  : level input
//   rise : sig & ~sig_q (combinational)
// The history register resets to 1, so a level already high when reset is
// released does not register as a rising edge.
// -----------------------------------------------------------------------------
module edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic sig,
    output logic rise
);

    logic sig_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sig_q <= 1'b1;
        end else begin
            sig_q <= sig;
        end
    end

    assign rise = sig & ~sig_q;

endmodule

// File: rtl/min_sec_counter.sv
// -----------------------------------------------------------------------------
// min_sec_counter
// Minutes/seconds counter with a mode-button set FSM (RUN -> SET_HR -> SET_MIN).
//   seconds_clk : time base, one rising edge per second
//   rst         : asynchronous, active-high reset
//   mode        : debounced mode level; each rising edge advances the set FSM
//   inc         : debounced increment level, sampled each edge in set states
//   hold        : (HOLD_EN builds only) freezes counting while in RUN
//   seconds     : 0..SEC_MAX
//   minutes     : 0..MIN_MAX
//   hour_set    : set strobe for the downstream hours counter
//   set_state   : current FSM state (0 RUN, 1 SET_HR, 2 SET_MIN)
// Optional feature macro: HOLD_EN.
// The downstream hours counter advances when it sees RUN with
// seconds == SEC_MAX and minutes == MIN_MAX, the same edge on which this block
// wraps to 00:00. Seconds are cleared on entry to the set states, so that
// condition can never occur while setting.
// -----------------------------------------------------------------------------
module min_sec_counter
    import clock_pkg::*;
#(
    parameter int SEC_MAX = SEC_MAX_DEFAULT,
    parameter int MIN_MAX = MIN_MAX_DEFAULT
) (
    input  logic       seconds_clk,
    input  logic       rst,
    input  logic       mode,
    input  logic       inc,
`ifdef HOLD_EN
    input  logic       hold,
`endif
    output logic [5:0] seconds,
    output logic [5:0] minutes,
    output logic       hour_set,
    output logic [1:0] set_state
);

    localparam logic [5:0] SEC_TOP = 6'(SEC_MAX);
    localparam logic [5:0] MIN_TOP = 6'(MIN_MAX);

    set_state_e state, state_next;
    logic [5:0] seconds_next, minutes_next;
    logic       mode_rise;
    logic       run_hold;

    edge_detect u_mode_edge (
        .clk  (seconds_clk),
        .rst  (rst),
        .sig  (mode),
        .rise (mode_rise)
    );

`ifdef HOLD_EN
    assign run_hold = hold;
`else
    assign run_hold = 1'b0;
`endif

    always_ff @(posedge seconds_clk or posedge rst) begin
        if (rst) begin
            state   <= RUN;
            seconds <= 6'd0;
            minutes <= 6'd0;
        end else begin
            state   <= state_next;
            seconds <= seconds_next;
            minutes <= minutes_next;
        end
    end

    // A mode edge always wins over inc: the transition is taken and the
    // increment for that edge is dropped.
    always_comb begin
        state_next   = state;
        seconds_next = seconds;
        minutes_next = minutes;
        case (state)
            RUN: begin
                if (mode_rise) begin
                    state_next   = SET_HR;
                    seconds_next = 6'd0;
                end else if (!run_hold) begin
                    seconds_next = wrap_inc(seconds, SEC_TOP);
                    if (seconds == SEC_TOP) begin
                        minutes_next = wrap_inc(minutes, MIN_TOP);
                    end
                end
            end
            SET_HR: begin
                if (mode_rise) begin
                    state_next = SET_MIN;
                end
            end
            SET_MIN: begin
                if (mode_rise) begin
                    state_next = RUN;
                end else if (inc) begin
                    // No carry into hours while setting minutes.
                    minutes_next = wrap_inc(minutes, MIN_TOP);
                end
            end
            default: begin
                state_next   = RUN;
                seconds_next = 6'd0;
            end
        endcase
    end

    assign hour_set  = (state == SET_HR) & inc & ~mode_rise;
    assign set_state = state;

endmodule

// File: tb/tb_min_sec_counter.sv
// -----------------------------------------------------------------------------
// tb_min_sec_counter
// Directed bench for min_sec_counter with a small downstream hours model.
// -----------------------------------------------------------------------------
module tb_min_sec_counter;

    logic       seconds_clk;
    logic       rst;
    logic       mode;
    logic       inc;
`ifdef HOLD_EN
    logic       hold;
`endif
    logic [5:0] seconds;
    logic [5:0] minutes;
    logic       hour_set;
    logic [1:0] set_state;

    int n_compared   = 0;
    int n_mismatched = 0;
    int hours        = 0;

    min_sec_counter dut (
        .seconds_clk (seconds_clk),
        .rst         (rst),
        .mode        (mode),
        .inc         (inc),
`ifdef HOLD_EN
        .hold        (hold),
`endif
        .seconds     (seconds),
        .minutes     (minutes),
        .hour_set    (hour_set),
        .set_state   (set_state)
    );

    // clock / reset
    initial seconds_clk = 1'b0;
    always #5 seconds_clk = ~seconds_clk;

    // Downstream hours counter: set strobe, or the 59:59 rollover in RUN.
    always @(posedge seconds_clk) begin
        if (hour_set === 1'b1 ||
            (set_state === 2'd0 && seconds === 6'd59 && minutes === 6'd59)) begin
            hours <= hours + 1;
        end
    end

    // driver tasks
    task automatic tick();
        @(posedge seconds_clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
        end
    endtask

    task automatic check(input string tag, input logic [31:0] observed,
                         input logic [31:0] expected);
        n_compared++;
        assert (observed === expected)
        else begin
            n_mismatched++;
            $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic check_time(input string tag, input int exp_min, input int exp_sec,
                              input int exp_state);
        check({tag, ".seconds"}, 32'(seconds), 32'(exp_sec));
        check({tag, ".minutes"}, 32'(minutes), 32'(exp_min));
        check({tag, ".state"}, 32'(set_state), 32'(exp_state));
    endtask

    initial begin
        rst  = 1'b1;
        mode = 1'b0;
        inc  = 1'b0;
`ifdef HOLD_EN
        hold = 1'b0;
`endif
        #12;
        check_time("reset", 0, 0, 0);
        check("reset.hour_set", 32'(hour_set), 32'd0);
        rst = 1'b0;

        // 61 edges in RUN -> 01:01
        ticks(61);
        check_time("run61", 1, 1, 0);

        // asynchronous reset between edges, then run to 00:37
        #2;
        rst = 1'b1;
        #1;
        check_time("async_rst", 0, 0, 0);
        rst = 1'b0;
        ticks(37);
        check_time("run37", 0, 37, 0);

        // mode rise -> SET_HR with seconds cleared, minutes kept
        mode = 1'b1;
        tick();
        check_time("enter_set_hr", 0, 0, 1);
        check("set_hr.hour_set_idle", 32'(hour_set), 32'd0);
        mode = 1'b0;

        // three increment edges in SET_HR
        inc = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("set_hr.hour_set", 32'(hour_set), 32'd1);
            tick();
        end
        check_time("after_hr_inc", 0, 0, 1);
        check("hours_after_set", 32'(hours), 32'd3);

        // mode and inc together: transition, no strobe
        mode = 1'b1;
        #1;
        check("coincide.hour_set", 32'(hour_set), 32'd0);
        tick();
        check_time("enter_set_min", 0, 0, 2);
        check("hours_coincide", 32'(hours), 32'd3);
        mode = 1'b0;

        // SET_MIN: 59 increments, then wrap with no carry into hours
        ticks(59);
        check_time("set_min59", 59, 0, 2);
        tick();
        check_time("set_min_wrap", 0, 0, 2);
        check("hours_min_wrap", 32'(hours), 32'd3);
        ticks(59);
        check_time("set_min59b", 59, 0, 2);

        // mode and inc together in SET_MIN: back to RUN, minutes unchanged
        mode = 1'b1;
        tick();
        check_time("back_to_run", 59, 0, 0);
        mode = 1'b0;
        inc  = 1'b0;

        // run to 59:59, then roll over to 00:00 with one hours advance
        ticks(59);
        check_time("at_59_59", 59, 59, 0);
        check("hours_59_59", 32'(hours), 32'd3);
        tick();
        check_time("rollover", 0, 0, 0);
        check("hours_rollover", 32'(hours), 32'd4);

        // enter SET_MIN, bump minutes twice, then reset mid-cycle
        mode = 1'b1; tick();
        mode = 1'b0; tick();
        mode = 1'b1; tick();
        mode = 1'b0;
        inc  = 1'b1;
        ticks(2);
        inc  = 1'b0;
        check_time("pre_rst_set_min", 2, 0, 2);
        #3;
        rst = 1'b1;
        #1;
        check_time("rst_mid_set", 0, 0, 0);
        check("rst_mid_set.hour_set", 32'(hour_set), 32'd0);
        mode = 1'b1;
        #2;
        rst = 1'b0;
        ticks(2);
        check_time("mode_held_release", 0, 2, 0);
        mode = 1'b0;

`ifdef HOLD_EN
        rst = 1'b1;
        #2;
        rst = 1'b0;
        ticks(5);
        check_time("hold_start", 0, 5, 0);
        hold = 1'b1;
        ticks(10);
        check_time("hold_frozen", 0, 5, 0);
        hold = 1'b0;
        tick();
        check_time("hold_resume", 0, 6, 0);
`endif

        // final report
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/min_sec_counter.md
MIN_SEC_COUNTER -- requirements
Module: min_sec_counter

Interface
REQ-001 SHALL have parameter SEC_MAX, default 59, terminal seconds value.
REQ-002 SHALL have parameter MIN_MAX, default 59, terminal minutes value.
REQ-003 SHALL have port seconds_clk  input  1  time-base clock, one edge per second.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port mode  input  1  debounced mode button level; a rising edge advances the set FSM.
REQ-006 SHALL have port inc  input  1  debounced increment level; sampled every seconds_clk edge while in a set state.
REQ-007 SHALL have port seconds  output  6  current seconds, 0..SEC_MAX.
REQ-008 SHALL have port minutes  output  6  current minutes, 0..MIN_MAX.
REQ-009 SHALL have port hour_set  output  1  set strobe for the downstream hours counter's set input.
REQ-010 SHALL have port set_state  output  2  FSM state: 0 RUN, 1 SET_HR, 2 SET_MIN.

Function
REQ-011 SHALL detect mode_rise = mode & ~mode_q, where mode_q is mode registered on seconds_clk.
REQ-012 SHALL implement FSM RUN -> SET_HR -> SET_MIN -> RUN, advancing one step per mode_rise and holding otherwise.
REQ-013 In RUN, SHALL increment seconds every edge, wrapping SEC_MAX -> 0.
REQ-014 In RUN, when seconds == SEC_MAX, SHALL on the same edge increment minutes, wrapping MIN_MAX -> 0.
REQ-015 SHALL therefore go from 59:59 to 00:00 on the same edge on which the downstream hours counter advances.
REQ-016 SHALL clear seconds to 0 on the edge that transitions RUN -> SET_HR.
REQ-017 SHALL hold seconds in every set state.
REQ-018 SHALL hold minutes in SET_HR.
REQ-019 In SET_MIN, SHALL increment minutes by 1 per edge with inc = 1, wrapping MIN_MAX -> 0 with no carry to hours.
REQ-020 SHALL drive hour_set combinationally as (set_state == SET_HR) & inc & ~mode_rise.
REQ-021 On an edge where mode_rise and inc coincide, SHALL take the state transition and ignore inc (no increment, no hour_set).
REQ-022 SHALL keep seconds ≠ SEC_MAX in every set state, so the downstream counter never auto-advances during setting.
REQ-023 SHALL use unsigned 6-bit arithmetic with compare-and-wrap and no modulo operators.
REQ-024 SHALL never emit values above SEC_MAX or MIN_MAX.

Reset
REQ-025 On rst = 1, SHALL immediately and asynchronously set seconds = 0, minutes = 0, set_state = RUN, mode_q = 1, and hold-related state cleared.
REQ-026 SHALL hold hour_set at 0 while rst = 1.
REQ-027 With mode_q resetting to 1, a mode level held high through reset release SHALL NOT enter SET_HR.
REQ-028 Reset asserted mid-set SHALL return the FSM to RUN with no partial increment.

Configuration
REQ-029 With HOLD_EN defined, SHALL add input port hold (1 bit); hold = 1 in RUN freezes seconds and minutes, and hold has no effect in set states.
REQ-030 Without HOLD_EN, SHALL have no hold port and count unconditionally in RUN.

Structure
REQ-031 SHALL define the state encoding (RUN, SET_HR, SET_MIN) and the default SEC_MAX/MIN_MAX constants in the shared package clock_pkg.
REQ-032 SHALL instantiate one sub-module, edge_detect, to register mode and produce mode_rise.
REQ-033 SHALL place all counter and FSM logic in min_sec_counter.

Verification
REQ-034 Reset, then 61 edges in RUN -> seconds = 1, minutes = 1.
REQ-035 Preload via SET_MIN (59 inc pulses), run to 59:59, then 1 edge -> 00:00; downstream hours increments once on that edge.
REQ-036 Running at 00:37, mode rise -> set_state = SET_HR, seconds = 0; 3 edges with inc = 1 -> hour_set high for 3 edges, minutes unchanged.
REQ-037 In SET_MIN at minutes = 59, inc for 1 edge -> minutes = 0, hours unchanged; mode and inc high together -> state = RUN, minutes unchanged.
REQ-038 Assert rst asynchronously mid-edge in SET_MIN -> outputs 00:00 and state RUN before the next edge; mode held high across release -> no state change.
REQ-039 HOLD_EN build: hold = 1 for 10 edges at 00:05 -> remains 00:05; hold = 0 -> resumes at 00:06.
